// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit serializer: FSM state encoding,
// character-length codes, the default oversample ratio and the mapping from
// a length code to a data-bit count.
package uart_pkg;

    // Transmitter FSM states, 3-bit encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // data_len codes
    localparam logic [1:0] LEN_5 = 2'b00;
    localparam logic [1:0] LEN_6 = 2'b01;
    localparam logic [1:0] LEN_7 = 2'b10;
    localparam logic [1:0] LEN_8 = 2'b11;

    // Baud ticks per bit time unless the instance overrides it
    localparam int OVERSAMPLE_DEF = 16;

    // Number of data bits carried by a character for a given length code
    function automatic logic [3:0] len_bits(input logic [1:0] code);
        logic [3:0] n;
        case (code)
            LEN_5:   n = 4'd5;
            LEN_6:   n = 4'd6;
            LEN_7:   n = 4'd7;
            LEN_8:   n = 4'd8;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Character handshake between the TX holding register/FIFO (master) and the
// UART transmit serializer (slave). One character moves on every pclk edge
// where tx_valid and tx_ready are both high.
interface uart_tx_serializer_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer. Takes one character per handshake and shifts it
// out on txd as: start bit, 5-8 data bits LSB first, optional parity, then
// one or two stop bits. Bit timing comes from the external baud-tick
// generator (bclk_tx), which this block enables through tx_bclk_en whenever
// a frame is in flight; the generator restarts its phase on enable, so each
// frame starts with a fresh tick phase.
//
// Build option: define UART_TX_PARITY_EN to build the PARITY state and the
// parity XOR logic. Without it, parity_en/parity_odd are accepted but ignored
// and the last data bit is followed directly by the stop bit(s).
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                       pclk,
    input  logic                       preset,
    uart_tx_serializer_if.slave        tx_if,
    input  logic [1:0]                 data_len,
    input  logic                       stop_2,
    input  logic                       parity_en,
    input  logic                       parity_odd,
    input  logic                       bclk_tx,
    output logic                       tx_bclk_en,
    output logic                       txd,
    output logic                       tx_busy,
    output logic                       tx_done
);

    // Tick count value whose tick closes the current bit time
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

    // Control state
    tx_state_e  state_q, state_d;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic       stop_q, stop_d;      // a second stop bit is still owed
    logic       txd_q, txd_d;
    logic       done_q, done_d;

    // Character and frame format captured at the handshake
    logic [7:0] data_q;
    logic [1:0] len_q;
    logic       stop2_q;

    // Decode helpers
    logic       load;
    logic       bit_end;
    logic       last_data;
    logic [2:0] bit_nxt;

`ifdef UART_TX_PARITY_EN
    logic       par_en_q;
    logic       par_odd_q;

    // Parity over the first len data bits; odd parity inverts the XOR
    function automatic logic parity_of(input logic [7:0] d,
                                       input logic [1:0] code,
                                       input logic       odd);
        logic p;
        p = odd;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(len_bits(code))) begin
                p = p ^ d[i];
            end
        end
        return p;
    endfunction
`else
    // Parity inputs stay on the port list for integration but carry no function
    logic unused_parity_cfg;
    assign unused_parity_cfg = parity_en ^ parity_odd;
`endif

    assign bit_end   = bclk_tx && (tick_q == TICK_LAST);
    assign last_data = ({1'b0, bit_q} == (len_bits(len_q) - 4'd1));
    assign bit_nxt   = bit_q + 3'd1;

    assign tx_if.tx_ready = (state_q == ST_IDLE);
    assign tx_busy        = (state_q != ST_IDLE);
    assign tx_bclk_en     = (state_q != ST_IDLE);
    assign txd            = txd_q;
    assign tx_done        = done_q;

    // Next-state, counter and line-level decode for the frame sequencer
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        stop_d  = stop_q;
        txd_d   = txd_q;
        done_d  = 1'b0;
        load    = 1'b0;

        // Ticks only count while a frame is on the line; IDLE ignores them
        if ((state_q != ST_IDLE) && bclk_tx) begin
            tick_d = bit_end ? 4'd0 : (tick_q + 4'd1);
        end

        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (tx_if.tx_valid) begin
                    load    = 1'b1;
                    state_d = ST_START;
                    txd_d   = 1'b0;
                    tick_d  = 4'd0;
                end
            end

            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    txd_d   = data_q[0];
                end
            end

            ST_DATA: begin
                if (bit_end) begin
                    if (last_data) begin
`ifdef UART_TX_PARITY_EN
                        if (par_en_q) begin
                            state_d = ST_PARITY;
                            txd_d   = parity_of(data_q, len_q, par_odd_q);
                        end else begin
                            state_d = ST_STOP;
                            txd_d   = 1'b1;
                            stop_d  = stop2_q;
                        end
`else
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
                        stop_d  = stop2_q;
`endif
                    end else begin
                        bit_d = bit_nxt;
                        txd_d = data_q[bit_nxt];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    txd_d   = 1'b1;
                    stop_d  = stop2_q;
                end
            end
`endif

            ST_STOP: begin
                txd_d = 1'b1;
                if (bit_end) begin
                    if (stop_q) begin
                        stop_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    // Control registers: FSM state, counters, line driver and done pulse
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= ST_IDLE;
            tick_q  <= 4'd0;
            bit_q   <= 3'd0;
            stop_q  <= 1'b0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
        end
    end

    // Character and format capture; a reset in the same cycle blocks the load
    always_ff @(posedge pclk) begin
        if (load && !preset) begin
            data_q    <= tx_if.tx_data;
            len_q     <= data_len;
            stop2_q   <= stop_2;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= parity_en;
            par_odd_q <= parity_odd;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer. Includes a behavioural baud-tick
// generator (restarts on enable, one tick every D pclk cycles), a table of
// directed frames with hand-computed frame lengths and parity values, a
// back-to-back pair, a config-change-mid-frame case, reset corner cases and
// randomized frames checked against a bit-list reference model.
module tb_uart_tx_serializer;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic [1:0] data_len = 2'b00;
    logic       stop_2 = 1'b0;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       bclk_tx = 1'b0;
    logic       tx_bclk_en;
    logic       txd;
    logic       tx_busy;
    logic       tx_done;

    int gen_div = 1;
    int gen_cnt = 0;
    int n_chk = 0;
    int n_err = 0;

    uart_tx_serializer_if tx_if();

    uart_tx_serializer #(.OVERSAMPLE(16)) dut (
        .pclk       (pclk),
        .preset     (preset),
        .tx_if      (tx_if),
        .data_len   (data_len),
        .stop_2     (stop_2),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .bclk_tx    (bclk_tx),
        .tx_bclk_en (tx_bclk_en),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 pclk = ~pclk;

    // Baud-tick generator: phase restarts whenever enable is low
    always @(posedge pclk) begin
        if (!tx_bclk_en) begin
            gen_cnt <= 0;
            bclk_tx <= 1'b0;
        end else begin
            bclk_tx <= (gen_cnt == 0);
            gen_cnt <= (gen_cnt >= gen_div - 1) ? 0 : gen_cnt + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string      name;
        logic [7:0] data;
        logic [1:0] len;
        logic       s2;
        logic       pe;
        logic       po;
        int         div;
        bit         chain;
        bit         scramble;
        int         exp_len_np;
        int         exp_len_p;
        logic       exp_par;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    // Present a character and wait (bounded) for the handshake edge
    task automatic start_frame(input logic [7:0] d, input logic [1:0] len,
                               input logic s2, input logic pe, input logic po,
                               input int div);
        int w;
        gen_div        = div;
        tx_if.tx_data  = d;
        data_len       = len;
        stop_2         = s2;
        parity_en      = pe;
        parity_odd     = po;
        tx_if.tx_valid = 1'b1;
        w = 0;
        @(negedge pclk);
        while (tx_if.tx_ready !== 1'b1 && w < 2000) begin
            @(negedge pclk);
            w++;
        end
        if (w >= 2000) chk("handshake_wait", 32'(w), 0);
        @(posedge pclk);
    endtask

    // Follow one frame from the cycle after its handshake edge to its IDLE cycle
    task automatic check_frame(input string nm, input logic [7:0] d, input logic [1:0] len,
                               input logic s2, input logic pe, input logic po, input int div,
                               input int exp_len, input logic exp_par,
                               input bit keep_valid, input logic [7:0] nd, input logic [1:0] nlen,
                               input logic ns2, input logic npe, input logic npo,
                               input bit scramble);
        logic q[$];
        int   nb, first_len, bit_len, total, idx, en_cnt, bad, first_bad, ctrl_bad;
        bit   ended;
        logic expv;
`ifdef UART_TX_PARITY_EN
        int   par_k;
        logic par_seen;
        logic p;
`endif
        nb = 5 + int'(len);
        q = {};
        q.push_back(1'b0);
        for (int i = 0; i < nb; i++) q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        p = po;
        for (int i = 0; i < nb; i++) p = p ^ d[i];
        if (pe) q.push_back(p);
        par_k = (15 * div + 2) + 16 * div * nb + 8 * div;
        par_seen = 1'bx;
`endif
        q.push_back(1'b1);
        if (s2) q.push_back(1'b1);
        first_len = 15 * div + 2;
        bit_len   = 16 * div;
        total     = first_len + bit_len * (q.size() - 1);

        ended = 0; en_cnt = 0; bad = 0; first_bad = -1; ctrl_bad = 0;
        for (int k = 0; k < total + 200 && !ended; k++) begin
            @(negedge pclk);
            if (k == 0) begin
                if (keep_valid) begin
                    tx_if.tx_data = nd;
                    data_len = nlen; stop_2 = ns2; parity_en = npe; parity_odd = npo;
                end else begin
                    tx_if.tx_valid = 1'b0;
                end
                if (scramble) begin
                    data_len = ~len; stop_2 = ~s2; parity_en = ~pe; parity_odd = ~po;
                end
            end
            if (k < first_len) idx = 0;
            else idx = 1 + (k - first_len) / bit_len;
            expv = (idx < q.size()) ? q[idx] : 1'b1;
`ifdef UART_TX_PARITY_EN
            if (k == par_k) par_seen = txd;
`endif
            if (tx_bclk_en === 1'b1) begin
                en_cnt++;
                if (txd !== expv) begin
                    bad++;
                    if (first_bad < 0) first_bad = k;
                end
                if (tx_done !== 1'b0 || tx_ready_s() !== 1'b0 || tx_busy !== 1'b1) ctrl_bad++;
            end else begin
                ended = 1;
                chk({nm, ".idle_done"}, tx_done, 1);
                chk({nm, ".idle_txd"}, txd, 1);
                chk({nm, ".idle_ready"}, tx_ready_s(), 1);
            end
        end
        chk({nm, ".ended"}, ended, 1);
        if (bad != 0) $display("  %s: first bad txd cycle %0d", nm, first_bad);
        chk({nm, ".txd_bad_cycles"}, 32'(bad), 0);
        chk({nm, ".bclk_en_cycles"}, 32'(en_cnt), 32'(exp_len));
        chk({nm, ".ctrl_bad_cycles"}, 32'(ctrl_bad), 0);
`ifdef UART_TX_PARITY_EN
        if (pe) chk({nm, ".parity_bit"}, par_seen, exp_par);
`endif
        if (!keep_valid) begin
            @(negedge pclk);
            chk({nm, ".done_one_cycle"}, tx_done, 0);
        end
    endtask

    function automatic logic tx_ready_s();
        return tx_if.tx_ready;
    endfunction

    initial begin
        vec_t       v[7];
        bit         pending;
        int         j, el, nb, dv;
        logic [7:0] d;
        logic [1:0] ln;
        logic       s2, pe, po, p;

        // 8N1 D=1 0x55: 17 + 8*16 + 16 = 161
        v[0] = '{"8n1_55",  8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 161, 161, 1'b0};
        // 5 bits, 2 stop, D=2: 32 + 5*32 + 64 = 256, parity adds 32
        v[1] = '{"5e2_ff",  8'hFF, 2'b00, 1'b1, 1'b1, 1'b0, 2, 1'b0, 1'b0, 256, 288, 1'b1};
        v[2] = '{"5o2_ff",  8'hFF, 2'b00, 1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b0, 256, 288, 1'b0};
        v[3] = '{"b2b_a5",  8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 161, 161, 1'b0};
        v[4] = '{"b2b_3c",  8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 161, 161, 1'b0};
        // 7 bits of 0x96 = 0010110 (three ones), odd -> 0: 17 + 7*16 + 16 = 145
        v[5] = '{"cfg_hold", 8'h96, 2'b10, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b1, 145, 161, 1'b0};
        // 6 bits of 0x2A = 101010 (three ones), even -> 1: 47 + 6*48 + 96 = 431
        v[6] = '{"6e2_2a",  8'h2A, 2'b01, 1'b1, 1'b1, 1'b0, 3, 1'b0, 1'b0, 431, 479, 1'b1};

        // Reset with tx_valid asserted: reset wins, nothing is accepted
        preset = 1'b1;
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data = 8'hA5;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("reset.ready", tx_ready_s(), 1);
        chk("reset.txd", txd, 1);
        chk("reset.busy", tx_busy, 0);
        chk("reset.bclk_en", tx_bclk_en, 0);
        chk("reset.done", tx_done, 0);
        preset = 1'b0;
        tx_if.tx_valid = 1'b0;
        @(negedge pclk);
        chk("reset.no_latch_busy", tx_busy, 0);

        // Directed table
        pending = 0;
        for (int i = 0; i < 7; i++) begin
            j = (i + 1 < 7) ? i + 1 : i;
`ifdef UART_TX_PARITY_EN
            el = v[i].exp_len_p;
`else
            el = v[i].exp_len_np;
`endif
            if (!pending) start_frame(v[i].data, v[i].len, v[i].s2, v[i].pe, v[i].po, v[i].div);
            pending = v[i].chain;
            check_frame(v[i].name, v[i].data, v[i].len, v[i].s2, v[i].pe, v[i].po, v[i].div,
                        el, v[i].exp_par, v[i].chain,
                        v[j].data, v[j].len, v[j].s2, v[j].pe, v[j].po, v[i].scramble);
        end

        // Reset during DATA bit 3 of an 8N1 frame of 0xC3 (bit 3 = 0)
        start_frame(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1);
        for (int k = 0; k < 70; k++) begin
            @(negedge pclk);
            if (k == 0) tx_if.tx_valid = 1'b0;
        end
        chk("rst_mid.busy_before", tx_busy, 1);
        chk("rst_mid.txd_bit3", txd, 0);
        preset = 1'b1;
        @(negedge pclk);
        chk("rst_mid.txd", txd, 1);
        chk("rst_mid.busy", tx_busy, 0);
        chk("rst_mid.bclk_en", tx_bclk_en, 0);
        chk("rst_mid.done", tx_done, 0);
        preset = 1'b0;
        el = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge pclk);
            if (tx_done !== 1'b0 || tx_busy !== 1'b0) el++;
        end
        chk("rst_mid.quiet_after", 32'(el), 0);
        start_frame(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1);
        check_frame("rst_mid.clean", 8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1, 161, 1'b0,
                    1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized frames against the bit-list model
        for (int r = 0; r < 8; r++) begin
            d  = 8'($urandom);
            ln = 2'($urandom_range(0, 3));
            s2 = 1'($urandom_range(0, 1));
            pe = 1'($urandom_range(0, 1));
            po = 1'($urandom_range(0, 1));
            dv = int'($urandom_range(1, 3));
            nb = 5 + int'(ln);
            p  = po;
            for (int i = 0; i < nb; i++) p = p ^ d[i];
            el = (15 * dv + 2) + 16 * dv * (nb + 1 + int'(s2));
`ifdef UART_TX_PARITY_EN
            if (pe) el = el + 16 * dv;
`endif
            start_frame(d, ln, s2, pe, po, dv);
            check_frame($sformatf("rand%0d", r), d, ln, s2, pe, po, dv, el, p,
                        1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
